// File: rtl/game_pkg.sv
// Shared types and constants for the player/obstacle game blocks.
package game_pkg;

  localparam int unsigned POS_W         = 10;
  localparam int unsigned COLOR_W       = 4;
  localparam int unsigned STEP_W        = 16;
  localparam int unsigned BTN_W         = 4;
  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;

  localparam logic [BTN_W-1:0] BTN_U = 4'b1000;
  localparam logic [BTN_W-1:0] BTN_D = 4'b0100;
  localparam logic [BTN_W-1:0] BTN_R = 4'b0010;
  localparam logic [BTN_W-1:0] BTN_L = 4'b0001;

  typedef enum logic {
    READY  = 1'b0,
    SETTLE = 1'b1
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

endpackage

// File: rtl/block_merge.sv
// Collapses the per-rectangle block flags into one flag per direction.
module block_merge
  import game_pkg::*;
#(
  parameter int unsigned NUM_RECT = 8
) (
  input  logic [NUM_RECT-1:0] up_block,
  input  logic [NUM_RECT-1:0] down_block,
  input  logic [NUM_RECT-1:0] left_block,
  input  logic [NUM_RECT-1:0] right_block,
  output dir_t                anyBlock_c
);

  always_comb begin
    anyBlock_c       = '0;
    anyBlock_c.up    = |up_block;
    anyBlock_c.down  = |down_block;
    anyBlock_c.left  = |left_block;
    anyBlock_c.right = |right_block;
  end

endmodule

// File: rtl/player_mover.sv
// Player sprite mover: one-pixel steps with screen wrap, colour cycling,
// and a settle cycle after every update so obstacle flags can catch up.
module player_mover
  import game_pkg::*;
#(
  parameter int unsigned NUM_RECT   = 8,
  parameter int unsigned P_WIDTH    = 12,
  parameter int unsigned P_HEIGHT   = 12,
  parameter int unsigned H_RES      = H_RES_DEFAULT,
  parameter int unsigned V_RES      = V_RES_DEFAULT,
  parameter int unsigned H_INIT     = 0,
  parameter int unsigned V_INIT     = 0,
  parameter int unsigned NUM_COLORS = 4
) (
  input  logic                btnClk,
  input  logic                rst,
  input  logic [BTN_W-1:0]    btns,
  input  logic                btnC,
  input  logic [NUM_RECT-1:0] up_block,
  input  logic [NUM_RECT-1:0] down_block,
  input  logic [NUM_RECT-1:0] left_block,
  input  logic [NUM_RECT-1:0] right_block,
  output logic [POS_W-1:0]    player_hPos,
  output logic [POS_W-1:0]    player_vPos,
  output logic [COLOR_W-1:0]  player_color,
  output logic                blocked,
  output logic                settling,
  output logic [STEP_W-1:0]   step_count
);

  localparam logic [POS_W-1:0] H_MAX = POS_W'(H_RES - P_WIDTH);
  localparam logic [POS_W-1:0] V_MAX = POS_W'(V_RES - P_HEIGHT);

  state_t               state, stateNext;
  logic                 btnCPrev;
  logic                 btnCRise_c;
  dir_t                 anyBlock_c;
  logic                 moveReq_c, moveBlk_c;
  logic [POS_W-1:0]     hPosNext, vPosNext;
  logic [COLOR_W-1:0]   colorNext;
  logic                 blockedNext;
  logic [STEP_W-1:0]    stepNext;

  block_merge #(.NUM_RECT(NUM_RECT)) uMerge (
    .up_block    (up_block),
    .down_block  (down_block),
    .left_block  (left_block),
    .right_block (right_block),
    .anyBlock_c  (anyBlock_c)
  );

  assign btnCRise_c = btnC & ~btnCPrev;

  // Only exact one-hot codes count as a move request.
  always_comb begin
    moveReq_c = 1'b1;
    moveBlk_c = 1'b0;
    case (btns)
      BTN_U:   moveBlk_c = anyBlock_c.up;
      BTN_D:   moveBlk_c = anyBlock_c.down;
      BTN_R:   moveBlk_c = anyBlock_c.right;
      BTN_L:   moveBlk_c = anyBlock_c.left;
      default: moveReq_c = 1'b0;
    endcase
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) state <= READY;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      READY:   if (btnCRise_c || (moveReq_c && !moveBlk_c)) stateNext = SETTLE;
      SETTLE:  stateNext = READY;
      default: stateNext = READY;
    endcase
  end

  // Colour edge outranks a move; a pre-empted move retries next READY.
  always_comb begin
    hPosNext    = player_hPos;
    vPosNext    = player_vPos;
    colorNext   = player_color;
    blockedNext = 1'b0;
    stepNext    = step_count;
    if (state == READY) begin
      if (btnCRise_c) begin
        colorNext = (32'(player_color) + 32'd1 >= NUM_COLORS) ? '0
                                                             : player_color + COLOR_W'(1);
      end else if (moveReq_c && moveBlk_c) begin
        blockedNext = 1'b1;
      end else if (moveReq_c) begin
        case (btns)
          BTN_U:   vPosNext = (player_vPos == '0)    ? V_MAX : player_vPos - POS_W'(1);
          BTN_D:   vPosNext = (player_vPos >= V_MAX) ? '0    : player_vPos + POS_W'(1);
          BTN_L:   hPosNext = (player_hPos == '0)    ? H_MAX : player_hPos - POS_W'(1);
          BTN_R:   hPosNext = (player_hPos >= H_MAX) ? '0    : player_hPos + POS_W'(1);
          default: ;
        endcase
        if (step_count != '1) stepNext = step_count + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      btnCPrev     <= 1'b0;
      player_hPos  <= POS_W'(H_INIT);
      player_vPos  <= POS_W'(V_INIT);
      player_color <= '0;
      blocked      <= 1'b0;
      settling     <= 1'b0;
      step_count   <= '0;
    end else begin
      btnCPrev     <= btnC;
      player_hPos  <= hPosNext;
      player_vPos  <= vPosNext;
      player_color <= colorNext;
      blocked      <= blockedNext;
      settling     <= (stateNext == SETTLE);
      step_count   <= stepNext;
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Vector-table bench for player_mover with a queue of expected outputs.
module tb_player_mover;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [3:0]  c;
    logic        b;
    logic        s;
    logic [15:0] st;
  } out_t;

  typedef struct {
    logic [3:0] btns;
    logic       btnC;
    logic [7:0] up, dn, lf, rt;
    out_t       exp;
  } vec_t;

  logic        btnClk = 1'b0;
  logic        rst;
  logic [3:0]  btns;
  logic        btnC;
  logic [7:0]  up_block, down_block, left_block, right_block;
  logic [9:0]  player_hPos, player_vPos;
  logic [3:0]  player_color;
  logic        blocked, settling;
  logic [15:0] step_count;

  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[$];
  out_t sb[$];

  player_mover dut (
    .btnClk       (btnClk),
    .rst          (rst),
    .btns         (btns),
    .btnC         (btnC),
    .up_block     (up_block),
    .down_block   (down_block),
    .left_block   (left_block),
    .right_block  (right_block),
    .player_hPos  (player_hPos),
    .player_vPos  (player_vPos),
    .player_color (player_color),
    .blocked      (blocked),
    .settling     (settling),
    .step_count   (step_count)
  );

  always #5 btnClk = ~btnClk;

  function automatic out_t mk(input int h, input int v, input int c,
                              input int b, input int s, input int st);
    out_t o;
    o.h = 10'(h); o.v = 10'(v); o.c = 4'(c);
    o.b = 1'(b);  o.s = 1'(s);  o.st = 16'(st);
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o.h = player_hPos; o.v = player_vPos; o.c = player_color;
    o.b = blocked; o.s = settling; o.st = step_count;
    return o;
  endfunction

  task automatic addV(input logic [3:0] b, input logic c, input logic [7:0] u,
                      input logic [7:0] d, input logic [7:0] l, input logic [7:0] r,
                      input int eh, input int ev, input int ec, input int eb,
                      input int es, input int est);
    vec_t t;
    t.btns = b; t.btnC = c; t.up = u; t.dn = d; t.lf = l; t.rt = r;
    t.exp = mk(eh, ev, ec, eb, es, est);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input out_t exp, input out_t act);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got h=%0d v=%0d c=%0d blk=%0b set=%0b steps=%0d, want h=%0d v=%0d c=%0d blk=%0b set=%0b steps=%0d",
               name, act.h, act.v, act.c, act.b, act.s, act.st,
               exp.h, exp.v, exp.c, exp.b, exp.s, exp.st);
    end
  endtask

  task automatic drive(input vec_t t);
    btns = t.btns; btnC = t.btnC;
    up_block = t.up; down_block = t.dn; left_block = t.lf; right_block = t.rt;
    sb.push_back(t.exp);
  endtask

  task automatic collect(input string name);
    out_t e;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL %s: scoreboard empty, got h=%0d, want a queued entry", name, player_hPos);
    end else begin
      e = sb.pop_front();
      chk(name, e, actual());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    // btns, btnC, up, down, left, right  ->  h, v, c, blocked, settling, steps
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 1, 1);  // free move right
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 0, 1);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   2,   0, 0, 0, 1, 2);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   2,   0, 0, 0, 0, 2);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3,   0, 0, 0, 1, 3);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3,   0, 0, 0, 0, 3);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h20,   3,   0, 0, 1, 0, 3);  // right blocked
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h20,   3,   0, 0, 1, 0, 3);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h20,   3,   0, 0, 0, 0, 3);
    addV(4'hA, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3,   0, 0, 0, 0, 3);  // not one-hot
    addV(4'h8, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3, 468, 0, 0, 1, 4);  // up wrap
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3, 468, 0, 0, 0, 4);
    addV(4'h4, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3,   0, 0, 0, 1, 5);  // down wrap
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   3,   0, 0, 0, 0, 5);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   2,   0, 0, 0, 1, 6);  // held left
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   2,   0, 0, 0, 0, 6);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 1, 7);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 0, 7);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 0, 0, 1, 8);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 0, 0, 0, 8);
    addV(4'h1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 628,   0, 0, 0, 1, 9);  // left wrap
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 628,   0, 0, 0, 0, 9);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 0, 0, 1, 10); // right wrap
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 0, 0, 0, 10);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 1, 11);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 0, 0, 0, 11);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 1, 0, 1, 11); // colour once
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 1, 0, 0, 11);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 1, 0, 0, 11);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 1, 0, 0, 11);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 1, 0, 0, 11);
    addV(4'h1, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 2, 0, 1, 11); // colour beats move
    addV(4'h1, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   0, 2, 0, 0, 11);
    addV(4'h1, 1, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 2, 0, 1, 12);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   0, 2, 0, 0, 12);
    addV(4'h4, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   1, 2, 0, 1, 13); // settle gating
    addV(4'h4, 0, 8'h00, 8'h01, 8'h00, 8'h00,   0,   1, 2, 0, 0, 13);
    addV(4'h4, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   2, 2, 0, 1, 14);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   2, 2, 0, 0, 14);
    addV(4'h4, 0, 8'h00, 8'h80, 8'h00, 8'h00,   0,   2, 2, 1, 0, 14);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   0,   2, 2, 0, 0, 14);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 2, 0, 1, 15); // btnC edge lost in SETTLE
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 2, 0, 0, 15);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 2, 0, 0, 15);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 2, 0, 0, 15);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 3, 0, 1, 15); // colour wraps 3 -> 0
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 3, 0, 0, 15);
    addV(4'h0, 1, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 0, 0, 1, 15);
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 0, 0, 0, 15);
    addV(4'h8, 0, 8'h02, 8'h00, 8'h00, 8'h00,   1,   2, 0, 1, 0, 15); // up blocked
    addV(4'h1, 0, 8'h00, 8'h00, 8'h40, 8'h00,   1,   2, 0, 1, 0, 15); // left blocked
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   1,   2, 0, 0, 0, 15);
    addV(4'h2, 0, 8'h00, 8'h00, 8'hFF, 8'h00,   2,   2, 0, 0, 1, 16); // other-direction block ignored
    addV(4'h0, 0, 8'h00, 8'h00, 8'h00, 8'h00,   2,   2, 0, 0, 0, 16);

    rst = 1'b1; btns = '0; btnC = 1'b0;
    up_block = '0; down_block = '0; left_block = '0; right_block = '0;
    repeat (2) @(negedge btnClk);
    chk("reset_state", mk(0, 0, 0, 0, 0, 0), actual());
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge btnClk);
      drive(vecs[i]);
      @(posedge btnClk);
      #1;
      collect($sformatf("vec%0d", i));
    end

    // Reset asserted between edges while in SETTLE.
    @(negedge btnClk);
    addV(4'h2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 2, 0, 0, 1, 17);
    t = vecs[vecs.size()-1];
    drive(t);
    @(posedge btnClk);
    #1;
    collect("pre_reset_move");
    #2;
    rst = 1'b1; btns = '0;
    #1;
    chk("async_reset", mk(0, 0, 0, 0, 0, 0), actual());
    @(negedge btnClk);
    rst = 1'b0;
    @(negedge btnClk);
    addV(4'h4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1, 1);
    t = vecs[vecs.size()-1];
    drive(t);
    @(posedge btnClk);
    #1;
    collect("post_reset_move");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
